// File: rtl/multi_timer_pkg.sv
// Shared constants for the multi-channel timer: register offsets, modes and CTRL bit positions.
package multi_timer_pkg;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_CMP    = 2'd3;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;
  localparam logic [1:0] MODE_PWM      = 2'd2;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;
  localparam int CTRL_PS_LSB   = 8;
  localparam int CTRL_PEND     = 31;
endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: registers, prescaler, expiry logic and PWM compare.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int CW  = 32,
  parameter int PSW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        pwm
);
  logic           en_q, en_d;
  logic [1:0]     mode_q, mode_d;
  logic           im_q, im_d;
  logic           pend_q, pend_d;
  logic [PSW-1:0] ps_q, ps_d;
  logic [PSW-1:0] pscnt_q, pscnt_d;
  logic [CW-1:0]  preset_q, preset_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  cmp_q, cmp_d;

  logic tick, expiry, oneshot, wr_ctrl, wr_count;
  logic [31:0] ctrl_word;
  logic unused_wdata;

  assign unused_wdata = ^wdata;
  assign wr_ctrl  = we && (sel == REG_CTRL);
  assign wr_count = we && (sel == REG_COUNT);
  assign oneshot  = (mode_q == MODE_ONESHOT);
  assign tick     = en_q && (pscnt_q == ps_q);
  assign expiry   = tick && (count_q == '0);

  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    ps_d     = ps_q;
    pend_d   = pend_q;
    preset_d = preset_q;
    count_d  = count_q;
    cmp_d    = cmp_q;
    pscnt_d  = pscnt_q;

    if (wr_ctrl || wr_count)
      pscnt_d = '0;
    else if (en_q)
      pscnt_d = tick ? '0 : pscnt_q + 1'b1;

    if (tick)
      count_d = (count_q != '0) ? count_q - 1'b1 : (oneshot ? '0 : preset_q);
    if (wr_count)
      count_d = wdata[CW-1:0];

    // Clear first so a coincident expiry wins; written EN overrides the one-shot auto-clear.
    if (wr_ctrl) begin
      mode_d = wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
      im_d   = wdata[CTRL_IM];
      ps_d   = wdata[CTRL_PS_LSB +: PSW];
      if (wdata[CTRL_PEND])
        pend_d = 1'b0;
    end
    if (expiry) begin
      pend_d = 1'b1;
      if (oneshot)
        en_d = 1'b0;
    end
    if (wr_ctrl)
      en_d = wdata[CTRL_EN];

    if (we && sel == REG_PRESET)
      preset_d = wdata[CW-1:0];
    if (we && sel == REG_CMP)
      cmp_d = wdata[CW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      ps_q     <= '0;
      pend_q   <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
      cmp_q    <= '0;
      pscnt_q  <= '0;
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      ps_q     <= ps_d;
      pend_q   <= pend_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      pscnt_q  <= pscnt_d;
    end
  end

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_EN] = en_q;
    ctrl_word[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_q;
    ctrl_word[CTRL_IM] = im_q;
    ctrl_word[CTRL_PS_LSB +: PSW] = ps_q;
    ctrl_word[CTRL_PEND] = pend_q;
    case (sel)
      REG_CTRL:   rdata = ctrl_word;
      REG_PRESET: rdata = 32'(preset_q);
      REG_COUNT:  rdata = 32'(count_q);
      default:    rdata = 32'(cmp_q);
    endcase
  end

  assign irq = pend_q && im_q;
  assign pwm = en_q && (mode_q == MODE_PWM) && (count_q < cmp_q);
endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer top: bus address decode, read-data channel mux and IRQ combine.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NCH = 2,
  parameter int CW  = 32,
  parameter int PSW = 8
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic [$clog2(NCH)+1:0]   ADDR_I,
  input  logic                     WE_I,
  input  logic [31:0]              DAT_I,
  output logic [31:0]              DAT_O,
  output logic                     IRQ,
  output logic [NCH-1:0]           PWM_O
);
  localparam int CSW = $clog2(NCH);

  logic [CSW-1:0] ch_sel;
  logic [1:0]     reg_sel;
  logic [31:0]    rdata_vec [NCH];
  logic [NCH-1:0] irq_vec;

  assign ch_sel  = ADDR_I[CSW+1:2];
  assign reg_sel = ADDR_I[1:0];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    timer_channel #(.CW(CW), .PSW(PSW)) u_ch (
      .clk   (CLK_I),
      .rst   (RST_I),
      .we    (WE_I && (ch_sel == CSW'(gi))),
      .sel   (reg_sel),
      .wdata (DAT_I),
      .rdata (rdata_vec[gi]),
      .irq   (irq_vec[gi]),
      .pwm   (PWM_O[gi])
    );
  end

  assign DAT_O = rdata_vec[ch_sel];
  assign IRQ   = |irq_vec;
endmodule
